// File: rtl/flash_wr_ctrl.sv
// SPI flash byte-program controller: each accepted byte becomes WREN, PP and RDSR polling.
// Optional ERASE_FIRST_EN: the first byte after reset is preceded by a sector erase at ADDR_INIT.
module flash_wr_ctrl #(
  parameter logic [23:0] ADDR_INIT   = 24'h00_0000,
  parameter int          CS_IDLE_CLK = 10,
  parameter logic [7:0]  CMD_WREN    = 8'h06,
  parameter logic [7:0]  CMD_PP      = 8'h02,
  parameter logic [7:0]  CMD_RDSR    = 8'h05
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  input  logic       miso,
  output logic       sck,
  output logic       cs_n,
  output logic       mosi,
  output logic       busy,
  output logic       ovf,
  output logic       wr_done
);

`ifdef ERASE_FIRST_EN
  localparam logic ERASE_EN = 1'b1;
`else
  localparam logic ERASE_EN = 1'b0;
`endif

  localparam logic [7:0] CMD_SE = 8'hD8;
  localparam int GW = $clog2(CS_IDLE_CLK + 1) + 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_IDLE_CLK);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WREN = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_PP   = 3'd3;
  localparam logic [2:0] S_RDSR = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_SE   = 3'd6;

  logic [2:0]    state_q, state_d, gap_nxt_q, gap_nxt_d;
  logic [1:0]    cnt_clk_q, cnt_clk_d;
  logic [2:0]    cnt_bit_q, cnt_bit_d, cnt_byte_q, cnt_byte_d;
  logic [GW-1:0] cnt_gap_q, cnt_gap_d;
  logic [23:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          ovf_q, ovf_d, erased_q, erased_d;

  logic       in_frame, frame_end;
  logic [7:0] cur_byte;
  logic [2:0] last_byte;

  // Byte currently shifted out and the index of the frame's final byte.
  always_comb begin
    cur_byte  = 8'h00;
    last_byte = 3'd0;
    in_frame  = 1'b1;
    case (state_q)
      S_WREN: cur_byte = CMD_WREN;
      S_SE: begin
        last_byte = 3'd3;
        case (cnt_byte_q)
          3'd0:    cur_byte = CMD_SE;
          3'd1:    cur_byte = ADDR_INIT[23:16];
          3'd2:    cur_byte = ADDR_INIT[15:8];
          default: cur_byte = ADDR_INIT[7:0];
        endcase
      end
      S_PP: begin
        last_byte = 3'd4;
        case (cnt_byte_q)
          3'd0:    cur_byte = CMD_PP;
          3'd1:    cur_byte = addr_q[23:16];
          3'd2:    cur_byte = addr_q[15:8];
          3'd3:    cur_byte = addr_q[7:0];
          default: cur_byte = data_q;
        endcase
      end
      S_RDSR: begin
        last_byte = 3'd1;
        cur_byte  = (cnt_byte_q == 3'd0) ? CMD_RDSR : 8'h00;
      end
      default: in_frame = 1'b0;
    endcase
    frame_end = in_frame && (cnt_clk_q == 2'd3) && (cnt_bit_q == 3'd7)
                && (cnt_byte_q == last_byte);
  end

  assign cs_n    = ~in_frame;
  assign sck     = in_frame & cnt_clk_q[1];
  assign mosi    = in_frame & cur_byte[~cnt_bit_q];
  assign busy    = (state_q != S_IDLE);
  assign wr_done = (state_q == S_DONE);
  assign ovf     = ovf_q;

  // Sequencer. A GAP lasts CS_IDLE_CLK+1 cycles: the cs_n rise cycle plus tSHSL.
  // Status is shifted MSB first, so WIP is the miso bit sampled at frame_end.
  always_comb begin
    state_d    = state_q;
    gap_nxt_d  = gap_nxt_q;
    cnt_clk_d  = cnt_clk_q;
    cnt_bit_d  = cnt_bit_q;
    cnt_byte_d = cnt_byte_q;
    cnt_gap_d  = cnt_gap_q;
    addr_d     = addr_q;
    data_d     = data_q;
    erased_d   = erased_q;
    ovf_d      = ovf_q | (pi_flag & (state_q != S_IDLE));

    if (in_frame) begin
      cnt_clk_d = cnt_clk_q + 2'd1;
      if (cnt_clk_q == 2'd3) begin
        cnt_bit_d = cnt_bit_q + 3'd1;
        if (cnt_bit_q == 3'd7) cnt_byte_d = cnt_byte_q + 3'd1;
      end
      if (frame_end) cnt_byte_d = 3'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (pi_flag) begin
          data_d  = pi_data;
          state_d = S_WREN;
        end
      end
      S_WREN: begin
        if (frame_end) begin
          state_d   = S_GAP;
          gap_nxt_d = (ERASE_EN && !erased_q) ? S_SE : S_PP;
        end
      end
      S_SE, S_PP: begin
        if (frame_end) begin
          state_d   = S_GAP;
          gap_nxt_d = S_RDSR;
        end
      end
      S_RDSR: begin
        if (frame_end) begin
          if (miso) begin
            state_d   = S_GAP;
            gap_nxt_d = S_RDSR;
          end else if (ERASE_EN && !erased_q) begin
            erased_d  = 1'b1;
            state_d   = S_GAP;
            gap_nxt_d = S_WREN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (cnt_gap_q == GAP_LAST) begin
          cnt_gap_d = '0;
          state_d   = gap_nxt_q;
        end else begin
          cnt_gap_d = cnt_gap_q + 1'b1;
        end
      end
      S_DONE: begin
        addr_d  = addr_q + 24'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      gap_nxt_q  <= S_IDLE;
      cnt_clk_q  <= 2'd0;
      cnt_bit_q  <= 3'd0;
      cnt_byte_q <= 3'd0;
      cnt_gap_q  <= '0;
      addr_q     <= ADDR_INIT;
      data_q     <= 8'h00;
      ovf_q      <= 1'b0;
      erased_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_nxt_q  <= gap_nxt_d;
      cnt_clk_q  <= cnt_clk_d;
      cnt_bit_q  <= cnt_bit_d;
      cnt_byte_q <= cnt_byte_d;
      cnt_gap_q  <= cnt_gap_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      erased_q   <= erased_d;
    end
  end

endmodule
